// File: rtl/clk_fwd_tx.sv
// clk_fwd_tx: divided complementary clock pair with en_req/en_ack start/stop.
// Optional edge counter output enabled by defining CLK_FWD_EDGE_CNT_EN.
module clk_fwd_tx #(
    parameter int DIV_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en_req,
    input  logic [DIV_W-1:0] div_half,
    output logic             en_ack,
    output logic             busy,
    output logic             out_p,
`ifdef CLK_FWD_EDGE_CNT_EN
    output logic [15:0]      edge_cnt,
`endif
    output logic             out_n
);

    localparam logic [DIV_W-1:0] ONE = {{(DIV_W-1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        STOP = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [DIV_W-1:0] cnt_q, cnt_d;
    logic [DIV_W-1:0] half_q, half_d;
    logic             out_p_q, out_p_d;
    logic             out_n_q;
    logic             en_ack_q, en_ack_d;
    logic             busy_q, busy_d;
    logic [DIV_W-1:0] last_cnt;
    logic             bnd;

    assign last_cnt = half_q - ONE;
    assign bnd      = (cnt_q == last_cnt);

    // Next-state: half-period counting and period-aligned start/stop
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        half_d   = half_q;
        out_p_d  = out_p_q;
        en_ack_d = en_ack_q;
        busy_d   = busy_q;
        unique case (state_q)
            IDLE: begin
                out_p_d = 1'b0;
                if (en_req) begin
                    state_d  = RUN;
                    out_p_d  = 1'b1;
                    cnt_d    = '0;
                    half_d   = (div_half == '0) ? ONE : div_half;
                    en_ack_d = 1'b1;
                    busy_d   = 1'b0;
                end
            end
            RUN, STOP: begin
                if (bnd) begin
                    cnt_d   = '0;
                    out_p_d = ~out_p_q;
                end else begin
                    cnt_d = cnt_q + ONE;
                end
                if (state_q == RUN) begin
                    if (!en_req) begin
                        state_d = STOP;
                        busy_d  = 1'b1;
                    end
                end else if (en_req) begin
                    state_d = RUN;
                    busy_d  = 1'b0;
                end else if (bnd && !out_p_q) begin
                    // Rising boundary while draining: park low instead
                    state_d  = IDLE;
                    cnt_d    = '0;
                    out_p_d  = 1'b0;
                    en_ack_d = 1'b0;
                    busy_d   = 1'b0;
                end
            end
            default: begin
                state_d  = IDLE;
                cnt_d    = '0;
                out_p_d  = 1'b0;
                en_ack_d = 1'b0;
                busy_d   = 1'b0;
            end
        endcase
    end

`ifdef CLK_FWD_EDGE_CNT_EN
    logic [15:0] edge_cnt_q, edge_cnt_d;

    // Count registered rising edges of out_p, wrapping naturally
    always_comb begin
        edge_cnt_d = edge_cnt_q;
        if (out_p_d && !out_p_q) begin
            edge_cnt_d = edge_cnt_q + 16'd1;
        end
    end

    // Edge counter register, cleared only by reset
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            edge_cnt_q <= '0;
        end else begin
            edge_cnt_q <= edge_cnt_d;
        end
    end

    assign edge_cnt = edge_cnt_q;
`endif

    // State and output registers; out_n loads the inverse of out_p's next value
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            half_q   <= ONE;
            out_p_q  <= 1'b0;
            out_n_q  <= 1'b1;
            en_ack_q <= 1'b0;
            busy_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            half_q   <= half_d;
            out_p_q  <= out_p_d;
            out_n_q  <= ~out_p_d;
            en_ack_q <= en_ack_d;
            busy_q   <= busy_d;
        end
    end

    assign out_p  = out_p_q;
    assign out_n  = out_n_q;
    assign en_ack = en_ack_q;
    assign busy   = busy_q;

endmodule

// File: tb/tb_clk_fwd_tx.sv
// tb_clk_fwd_tx: directed table-driven bench for clk_fwd_tx.
// Edge counter wrap check is built only with CLK_FWD_EDGE_CNT_EN.
module tb_clk_fwd_tx;

    logic       clk;
    logic       rst_n;
    logic       en_req;
    logic [7:0] div_half;
    logic       en_ack;
    logic       busy;
    logic       out_p;
    logic       out_n;
`ifdef CLK_FWD_EDGE_CNT_EN
    logic [15:0] edge_cnt;
`endif

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic       en;
        logic [7:0] div;
        logic       p;
        logic       ack;
        logic       bsy;
    } vec_t;

    vec_t vecs[$];

    clk_fwd_tx #(.DIV_W(8)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .en_req   (en_req),
        .div_half (div_half),
        .en_ack   (en_ack),
        .busy     (busy),
        .out_p    (out_p),
`ifdef CLK_FWD_EDGE_CNT_EN
        .edge_cnt (edge_cnt),
`endif
        .out_n    (out_n)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    function automatic void add(input logic en, input logic [7:0] div,
                                input logic p, input logic ack,
                                input logic bsy, input int reps);
        vec_t v;
        v.en  = en;
        v.div = div;
        v.p   = p;
        v.ack = ack;
        v.bsy = bsy;
        for (int i = 0; i < reps; i++) vecs.push_back(v);
    endfunction

    task automatic chk_pins(input string name, input logic p,
                            input logic ack, input logic bsy);
        chk(name, {28'd0, out_p, out_n, en_ack, busy},
            {28'd0, p, ~p, ack, bsy});
    endtask

    initial begin
        int hi;
        int lo;
        bit done;

        // A: H=2 held, then drop en_req at a rising boundary
        add(1, 8'd2, 1, 1, 0, 2);
        add(1, 8'd2, 0, 1, 0, 2);
        add(1, 8'd2, 1, 1, 0, 2);
        add(1, 8'd2, 0, 1, 0, 2);
        add(0, 8'd2, 1, 1, 1, 2);
        add(0, 8'd2, 0, 1, 1, 2);
        add(0, 8'd2, 0, 0, 0, 2);
        // B: H=3, drop en_req mid-high
        add(1, 8'd3, 1, 1, 0, 2);
        add(0, 8'd3, 1, 1, 1, 1);
        add(0, 8'd3, 0, 1, 1, 3);
        add(0, 8'd3, 0, 0, 0, 2);
        // C: div 0 acts as H=1; change to 5 ignored until restart
        add(1, 8'd0, 1, 1, 0, 1);
        add(1, 8'd0, 0, 1, 0, 1);
        add(1, 8'd0, 1, 1, 0, 1);
        add(1, 8'd5, 0, 1, 0, 1);
        add(1, 8'd5, 1, 1, 0, 1);
        add(0, 8'd5, 0, 1, 1, 1);
        add(0, 8'd5, 0, 0, 0, 2);
        // C2: one-cycle request with H=5 gives one full period
        add(1, 8'd5, 1, 1, 0, 1);
        add(0, 8'd5, 1, 1, 1, 4);
        add(0, 8'd5, 0, 1, 1, 5);
        add(0, 8'd5, 0, 0, 0, 2);
        // D: H=4, re-raise en_req while draining
        add(1, 8'd4, 1, 1, 0, 4);
        add(1, 8'd4, 0, 1, 0, 1);
        add(0, 8'd4, 0, 1, 1, 2);
        add(1, 8'd4, 0, 1, 0, 1);
        add(1, 8'd4, 1, 1, 0, 4);
        add(1, 8'd4, 0, 1, 0, 1);

        rst_n    = 1'b0;
        en_req   = 1'b0;
        div_half = 8'd0;
        repeat (2) @(posedge clk);
        #1;
        chk_pins("reset_hold", 1'b0, 1'b0, 1'b0);
        rst_n = 1'b1;

        foreach (vecs[i]) begin
            en_req   = vecs[i].en;
            div_half = vecs[i].div;
            @(posedge clk);
            #1;
            chk_pins($sformatf("vec%0d", i), vecs[i].p, vecs[i].ack,
                     vecs[i].bsy);
        end

        // Asynchronous reset while running, checked before any edge
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        chk_pins("reset_midrun", 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        rst_n  = 1'b1;
        en_req = 1'b0;

        // Largest half-period with a one-cycle request
        div_half = 8'd255;
        en_req   = 1'b1;
        @(posedge clk);
        #1;
        chk_pins("h255_first", 1'b1, 1'b1, 1'b0);
        en_req = 1'b0;
        hi     = 1;
        lo     = 0;
        done   = 1'b0;
        for (int n = 0; n < 1000 && !done; n++) begin
            @(posedge clk);
            #1;
            if (!en_ack) done = 1'b1;
            else if (out_p) hi++;
            else lo++;
        end
        chk("h255_high", hi, 255);
        chk("h255_low", lo, 255);
        chk_pins("h255_idle", 1'b0, 1'b0, 1'b0);
        repeat (3) begin
            @(posedge clk);
            #1;
            chk_pins("h255_stay_idle", 1'b0, 1'b0, 1'b0);
        end

`ifdef CLK_FWD_EDGE_CNT_EN
        begin
            int   rises;
            logic prev;
            rst_n = 1'b0;
            #1;
            chk("ecnt_reset", {16'd0, edge_cnt}, 32'd0);
            @(negedge clk);
            rst_n    = 1'b1;
            div_half = 8'd1;
            en_req   = 1'b1;
            rises    = 0;
            prev     = 1'b0;
            for (int n = 0; n < 140000 && rises < 65537; n++) begin
                @(posedge clk);
                #1;
                if (out_p && !prev) rises++;
                prev = out_p;
            end
            en_req = 1'b0;
            chk("ecnt_rises", rises, 65537);
            chk("ecnt_wrap", {16'd0, edge_cnt}, 32'd1);
        end
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/clk_fwd_tx.md
Name: clk_fwd_tx

Overview:
- Transmit-side clock forwarder. Derives a divided, complementary pair (out_p/out_n) from one input clock for a downstream differential output buffer; it is the driving end of the differential clock inputs received elsewhere in the design.
- Start and stop follow an en_req/en_ack handshake.
- Start/stop occur only on period boundaries, so no runt pulses ever reach the pair.

Parameters:
- DIV_W, 8: width of the half-period input div_half.

Ports:
- clk  input  1  sole clock; all logic on its rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- en_req  input  1  level request: 1 = forward the clock, 0 = stop.
- div_half  input  DIV_W  half-period in clk cycles; 0 is treated as 1.
- en_ack  output  1  1 while the pair is toggling (RUN or STOP).
- busy  output  1  1 in STOP (draining toward idle).
- out_p  output  1  forwarded clock, positive leg.
- out_n  output  1  always ~out_p, registered.

Behaviour:
- Reset (async, immediate on rst_n=0, including mid-run):
  - state=IDLE, cnt=0, half_q=1.
  - out_p=0, out_n=1, en_ack=0, busy=0.
- All outputs are registered. out_n is an independent flop loaded with ~out_p's next value, so the pair never skews.
- States:
  - IDLE:
    - out_p=0.
    - On en_req=1: next edge goes to RUN. On that edge: out_p=1, cnt=0, half_q=max(div_half,1), en_ack=1.
    - Latency: request sampled at edge N gives the first high at edge N.
  - RUN:
    - cnt increments each cycle.
    - When cnt==half_q-1: toggle out_p, cnt=0.
    - Result: high H cycles, low H cycles, period 2H (H=half_q).
    - div_half changes while running are ignored; they take effect at the next IDLE->RUN transition.
    - en_req=0 sampled: go to STOP next edge; busy=1; toggling continues unchanged.
  - STOP:
    - Continues the RUN counting.
    - At the boundary where out_p would go 0->1: go to IDLE instead. out_p stays 0, en_ack=0, busy=0 on that edge. The final low phase is therefore always a full H cycles.
    - en_req=1 sampled in STOP: return to RUN, busy=0, with no interruption of the waveform (cnt and out_p untouched).
- Boundary cases:
  - H=1: out_p toggles every cycle (div-by-2).
  - en_req pulse of 1 cycle from IDLE: RUN, then STOP. Produces exactly one full period (H high, H low), then IDLE.
  - en_req=0 on the same edge that IDLE->RUN completes: the start is not aborted; STOP follows and drains one full period.
  - cnt width is DIV_W; div_half all-ones is legal (H=2^DIV_W-1).
- en_ack rises with the first out_p high. It falls on the edge out_p is held low for idle. The requester sees en_ack=0 only after a complete final low phase.

Optional Feature:
- Macro CLK_FWD_EDGE_CNT_EN.
- Defined:
  - Adds output edge_cnt [15:0]: increments on every registered 0->1 of out_p, including the first high after IDLE.
  - Wraps 0xFFFF->0x0000.
  - Reset value 0. Not cleared by IDLE.
- Not defined: no edge_cnt port and no counter logic. All other behaviour is identical.

Test Plan:
- Reset: hold rst_n=0, then assert rst_n=0 mid-RUN -> out_p=0, out_n=1, en_ack=0, busy=0 immediately (same time step, no clk edge needed).
- div_half=2, en_req=1 held -> out_p from first edge: 1,1,0,0,1,1,0,0…; out_n inverse every cycle; en_ack=1 from first high.
- div_half=3, running; drop en_req mid-high -> busy=1 next edge; high completes (3 cycles) and low lasts 3 cycles; then IDLE with en_ack=0 and out_p=0, with no further high.
- div_half=0 -> behaves as H=1: out_p toggles every cycle. Changing div_half to 5 while running has no effect until stop and restart, after which H=5.
- In STOP with div_half=4, re-raise en_req before the boundary -> busy=0; waveform continues 4 high/4 low with no gap or stretch; en_ack stays 1 throughout.
- CLK_FWD_EDGE_CNT_EN defined, div_half=1, run 65537 rising edges -> edge_cnt=0x0001 after wrap. Undefined -> build has no edge_cnt port.
